// File: rtl/mult_div_unit.sv
// mult_div_unit: 32-bit iterative multiply/divide unit (MULTU, MULT, DIVU, DIV).
// One radix-2 step per clock. Signed operations run on magnitudes and are
// sign-corrected in a final fix-up cycle. Latency is 33 edges from start
// acceptance to the done pulse, independent of op and operand values.
//
// Ports:
//   clk    in   1   rising-edge clock
//   rst_n  in   1   asynchronous active-low reset
//   start  in   1   begin an operation (sampled only when idle)
//   op     in   2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   A      in  32   multiplicand / dividend
//   B      in  32   multiplier / divisor
//   busy   out  1   operation in progress (RUN, FIX)
//   done   out  1   one-cycle pulse, HI/LO/div0 valid
//   HI     out 32   product[63:32] or remainder
//   LO     out 32   product[31:0] or quotient
//   div0   out  1   completed divide had a zero divisor
module mult_div_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic        done,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        div0
);

    localparam int DATA_W = 32;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t              state, state_nxt;
    logic [4:0]          cnt;
    logic [1:0]          op_r;
    logic                sa_r, sb_r;
    logic [DATA_W-1:0]   a_r, b_r, wh, wl;
    logic signed [DATA_W-1:0] a_s, b_s;
    logic                sign_a, sign_b;
    logic [DATA_W:0]     shifted;
    logic [DATA_W:0]     sum;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   q_raw, r_raw, hi_fix, lo_fix;
    logic                dz;

    function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] x);
        return ~x + 32'd1;
    endfunction

    function automatic logic [2*DATA_W-1:0] neg64(input logic [2*DATA_W-1:0] x);
        return ~x + 64'd1;
    endfunction

    function automatic logic [DATA_W-1:0] mag32(input logic signed [DATA_W-1:0] x,
                                                 input logic neg);
        return neg ? neg32(x) : x;
    endfunction

    assign a_s    = A;
    assign b_s    = B;
    assign sign_a = op[0] & (a_s < 0);
    assign sign_b = op[0] & (b_s < 0);

    // Restoring-divide trial value and shift-add partial sum
    assign shifted = {wh, wl[DATA_W-1]};
    assign sum     = {1'b0, wh} + (wl[0] ? {1'b0, b_r} : 33'd0);

    // Sign correction applied in FIX; a zero divisor overrides the iterated result
    always_comb begin
        dz       = op_r[1] && (b_r == 32'd0);
        prod_fix = (op_r[0] && (sa_r ^ sb_r)) ? neg64({wh, wl}) : {wh, wl};
        q_raw    = dz ? 32'hFFFF_FFFF : wl;
        r_raw    = dz ? a_r : wh;
        if (op_r[1]) begin
            lo_fix = (op_r[0] && (sa_r ^ sb_r) && !dz) ? neg32(q_raw) : q_raw;
            hi_fix = (op_r[0] && sa_r) ? neg32(r_raw) : r_raw;
        end else begin
            lo_fix = prod_fix[DATA_W-1:0];
            hi_fix = prod_fix[2*DATA_W-1:DATA_W];
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= 5'd0;
            busy <= 1'b0;
            done <= 1'b0;
            HI   <= 32'd0;
            LO   <= 32'd0;
            div0 <= 1'b0;
        end else begin
            busy <= (state_nxt == RUN) || (state_nxt == FIX);
            done <= (state_nxt == DONE);
            if (state == IDLE)     cnt <= 5'd0;
            else if (state == RUN) cnt <= cnt + 5'd1;
            if (state == FIX) begin
                HI   <= hi_fix;
                LO   <= lo_fix;
                div0 <= dz;
            end
        end
    end

    // Operand capture and iteration datapath
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            op_r <= op;
            sa_r <= sign_a;
            sb_r <= sign_b;
            a_r  <= mag32(a_s, sign_a);
            b_r  <= mag32(b_s, sign_b);
            wh   <= 32'd0;
            wl   <= mag32(a_s, sign_a);
        end else if (state == RUN) begin
            if (op_r[1]) begin
                if (shifted >= {1'b0, b_r}) begin
                    wh <= 32'(shifted - {1'b0, b_r});
                    wl <= {wl[DATA_W-2:0], 1'b1};
                end else begin
                    wh <= shifted[DATA_W-1:0];
                    wl <= {wl[DATA_W-2:0], 1'b0};
                end
            end else begin
                wh <= sum[DATA_W:1];
                wl <= {sum[0], wl[DATA_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table plus
// hand-written sequences for ignored starts, input changes mid-run and
// asynchronous reset mid-run.
module tb_mult_div_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy, done, div0;
    logic [31:0] HI, LO;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } vec_t;

    vec_t vecs[14];

    mult_div_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .A(A), .B(B),
        .busy(busy), .done(done), .HI(HI), .LO(LO), .div0(div0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts edges from acceptance until done is seen; busy must stay high until then
    task automatic wait_done(input string nm, input int elapsed);
        int   lat;
        logic busy_ok;
        lat = elapsed;
        busy_ok = 1'b1;
        while (lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (done) break;
            if (!busy) busy_ok = 1'b0;
        end
        chk({nm, "_latency"}, lat, 33);
        chk({nm, "_busy_run"}, {31'd0, busy_ok}, 32'd1);
        chk({nm, "_busy_done"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0};
        vecs[2]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
        vecs[3]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0};
        vecs[4]  = '{2'd2, 32'h00000064, 32'd0,        32'h00000064, 32'hFFFFFFFF, 1'b1};
        vecs[5]  = '{2'd0, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0};
        vecs[6]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0};
        vecs[7]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0};
        vecs[8]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0};
        vecs[9]  = '{2'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 1'b0};
        vecs[10] = '{2'd3, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1};
        vecs[11] = '{2'd1, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
        vecs[12] = '{2'd2, 32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFF, 1'b0};
        vecs[13] = '{2'd2, 32'd5,        32'd10,       32'd5,        32'd0,        1'b0};

        // Asynchronous reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_div0", {31'd0, div0}, 32'd0);
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done($sformatf("v%0d", i), 0);
            chk($sformatf("v%0d_hi", i), HI, vecs[i].hi);
            chk($sformatf("v%0d_lo", i), LO, vecs[i].lo);
            chk($sformatf("v%0d_div0", i), {31'd0, div0}, {31'd0, vecs[i].dz});
            @(posedge clk);
            #1 chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
        end

        // Operands/op changed and start re-pulsed at N+5: result must be unchanged
        launch(2'd1, 32'hFFFFFFFD, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op = 2'd2; A = 32'h12345678; B = 32'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("midchg", 5);
        chk("midchg_hi", HI, 32'hFFFFFFFF);
        chk("midchg_lo", LO, 32'hFFFFFFF1);
        // Start while in DONE is dropped, not queued
        op = 2'd0; A = 32'd9; B = 32'd9; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("done_start_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("done_start_idle", {31'd0, busy | done}, 32'd0);
        chk("hold_hi", HI, 32'hFFFFFFFF);
        chk("hold_lo", LO, 32'hFFFFFFF1);

        // Reset mid-RUN at iteration 10
        launch(2'd2, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_done", {31'd0, done}, 32'd0);
        chk("midrst_hi", HI, 32'd0);
        chk("midrst_lo", LO, 32'd0);
        chk("midrst_div0", {31'd0, div0}, 32'd0);
        repeat (3) @(posedge clk);
        #1 chk("midrst_no_done", {31'd0, done | busy}, 32'd0);
        // Start presented together with reset release: taken on the first edge
        @(negedge clk);
        rst_n = 1'b1; op = 2'd2; A = 32'd100; B = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("restart", 0);
        chk("restart_hi", HI, 32'd2);
        chk("restart_lo", LO, 32'd14);
        chk("restart_div0", {31'd0, div0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
